instr_prefetch_queue: RTL and testbench
=======================================

// Module: instr_prefetch_queue
// PURPOSE
//  Fetch stage upstream of the 16-bit CPU decode/execute datapath. Issues word-address
//  fetches to an instruction memory over a req/ack handshake and buffers returned
//  instructions, each tagged with its PC, in a first-word-fall-through (FWFT) queue.
//  Decode pops the queue with valid/ready. A redirect (jump/branch/jr target) flushes the
//  queue and restarts fetch at the new PC, discarding any in-flight fetch.
// PARAMETERS
//  DEPTH    4   queue entries; power of two, >=2
//  PC_W     13  word-address width; matches the CPU PC
//  INSTR_W  16  instruction width
//  RESET_PC 0   first fetch address after reset
// PORTS
//  clk          in   1        rising-edge clock
//  rst          in   1        synchronous reset, active-high
//  mem_req      out  1        fetch request; held until mem_ack
//  mem_addr     out  PC_W     fetch word address; stable while mem_req=1
//  mem_ack      in   1        fetch complete; mem_rdata valid this cycle
//  mem_rdata    in   INSTR_W  fetched instruction
//  redirect     in   1        flush and restart fetch at redirect_pc (1-cycle pulse)
//  redirect_pc  in   PC_W     new fetch address
//  inst_valid   out  1        queue head valid (queue not empty)
//  inst_data    out  INSTR_W  queue head instruction
//  inst_pc      out  PC_W     PC of queue head
//  inst_ready   in   1        decode consumes head when inst_valid=1
//  count        out  $clog2(DEPTH+1)  occupied entries
// BEHAVIOUR
//  Reset (rst=1 at clk edge):
//   - state=IDLE, fetch_pc=RESET_PC, queue empty.
//   - mem_req=0, mem_addr=RESET_PC, inst_valid=0, inst_data=0, inst_pc=0, count=0.
//   - rst mid-fetch abandons the request. The memory side must tolerate req dropping on reset.
//  FSM states:
//   IDLE  no request outstanding.
//   WAIT  request outstanding; response will be kept.
//   DROP  request outstanding; response will be discarded.
//  Request outputs: mem_req = (state!=IDLE). mem_addr is a register, loaded only when
//   entering WAIT.
//  Queue space check, evaluated per cycle: space = (count - pop + push) < DEPTH.
//  Transitions, priority top-down:
//   - IDLE, redirect: fetch_pc <= redirect_pc; flush; stay IDLE.
//   - IDLE, space: mem_addr <= fetch_pc; go to WAIT.
//   - WAIT, redirect & mem_ack: drop rdata; fetch_pc <= redirect_pc; flush; go to IDLE.
//   - WAIT, redirect & !mem_ack: fetch_pc <= redirect_pc; flush; go to DROP.
//     mem_req/mem_addr stay stable; the request is never withdrawn.
//   - WAIT, mem_ack: push {fetch_pc, mem_rdata}; fetch_pc <= fetch_pc+1.
//     If space after the push: mem_addr <= fetch_pc+1 and stay WAIT
//     (supports 1 fetch/cycle on a zero-wait memory). Otherwise go to IDLE.
//   - DROP, mem_ack: discard; go to IDLE. A redirect in the same cycle also updates fetch_pc.
//   - DROP, redirect without ack: update fetch_pc; stay DROP.
//  Latency:
//   - First mem_req is 1 cycle after rst deasserts.
//   - inst_valid rises 1 cycle after the mem_ack that filled an empty queue.
//  Arithmetic: fetch_pc+1 wraps modulo 2^PC_W (0x1FFF -> 0x0000). No wrap flag.
//  Pop: head advances when inst_valid & inst_ready. Pop on empty is ignored.
//  Simultaneous events:
//   - Push and pop in one cycle: count unchanged. Legal at count=DEPTH only when a pop
//     occurs, which the space check guarantees.
//   - redirect with inst_ready: the pop is ignored; count=0 next cycle.
//  Invariant: at most one outstanding fetch; count <= DEPTH at all times.
//  mem_ack in IDLE is a protocol error: ignored, no push.
// STRUCTURE
//  - Shared constants file cpu_defs.vh: PC_W, INSTR_W, RESET_PC, and FSM state encodings
//    IFQ_IDLE=2'd0, IFQ_WAIT=2'd1, IFQ_DROP=2'd2.
//  - Sub-module sync_fifo_fwft (WIDTH=PC_W+INSTR_W, DEPTH). Its ports: push, pop, flush,
//    dout, count. It contains the head/tail pointers and the count.
//  - The top level holds the FSM, fetch_pc, mem_addr and the space/redirect logic.
// TESTING
//  1. Zero-wait memory (ack same cycle as req), inst_ready=1, RESET_PC=0.
//     -> mem_addr 0,1,2,... on consecutive cycles.
//     -> inst_pc 0,1,2,... one per cycle from cycle 2; inst_data = mem[pc].
//  2. inst_ready=0, DEPTH=4.
//     -> exactly 4 acks accepted; count=4; mem_req=0.
//     -> one pop -> a new request at addr 4 within 1 cycle.
//  3. 3-cycle ack memory; redirect to 0x0100 one cycle after a req at addr 5.
//     -> mem_addr stays 5 until ack; rdata discarded; queue empty.
//     -> next req addr=0x0100; first inst_pc=0x0100.
//  4. Redirect in the same cycle as mem_ack, with queue count=2.
//     -> count=0 next cycle; the acked word is never seen; next req = redirect_pc.
//  5. RESET_PC=0x1FFE, free-running.
//     -> fetch addresses 0x1FFE, 0x1FFF, 0x0000; inst_pc tags match.
//  6. rst=1 for 1 cycle while in WAIT with count=3.
//     -> next cycle all outputs at reset values; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instr_prefetch_queue_pkg.sv
// Shared constants and types for the instruction prefetch queue.
package instr_prefetch_queue_pkg;

  localparam int unsigned IFQ_DEPTH    = 4;
  localparam int unsigned IFQ_PC_W     = 13;
  localparam int unsigned IFQ_INSTR_W  = 16;
  localparam int unsigned IFQ_RESET_PC = 0;

  typedef enum logic [1:0] {
    IFQ_IDLE = 2'd0,
    IFQ_WAIT = 2'd1,
    IFQ_DROP = 2'd2
  } ifq_state_e;

  typedef struct packed {
    logic [IFQ_PC_W-1:0]    pc;
    logic [IFQ_INSTR_W-1:0] instr;
  } ifq_entry_t;

endpackage

// File: rtl/instr_prefetch_queue_fifo.sv
// First-word-fall-through FIFO with synchronous flush; holds {pc, instr} entries.
module sync_fifo_fwft #(
  parameter int unsigned WIDTH = 29,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             din,
  input  logic                         pop,
  input  logic                         flush,
  output logic [WIDTH-1:0]             dout,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_q, wr_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  // Pop on empty is ignored; push on full only accepted alongside a pop.
  always_comb begin
    do_pop  = pop && (cnt_q != '0);
    do_push = push && ((cnt_q != CW'(DEPTH)) || do_pop);
    cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (flush) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= din;
        wr_q        <= wr_q + AW'(1);
      end
      if (do_pop) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_d;
    end
  end

  assign dout  = mem_q[rd_q];
  assign count = cnt_q;

endmodule

// File: rtl/instr_prefetch_queue.sv
// Fetch stage: issues one outstanding word fetch at a time and queues {pc, instr}
// for decode; a redirect flushes the queue and discards any in-flight response.
module instr_prefetch_queue
  import instr_prefetch_queue_pkg::*;
#(
  parameter int unsigned            DEPTH    = IFQ_DEPTH,
  parameter int unsigned            PC_W     = IFQ_PC_W,
  parameter int unsigned            INSTR_W  = IFQ_INSTR_W,
  parameter logic [PC_W-1:0]        RESET_PC = PC_W'(IFQ_RESET_PC)
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         mem_req,
  output logic [PC_W-1:0]              mem_addr,
  input  logic                         mem_ack,
  input  logic [INSTR_W-1:0]           mem_rdata,
  input  logic                         redirect,
  input  logic [PC_W-1:0]              redirect_pc,
  output logic                         inst_valid,
  output logic [INSTR_W-1:0]           inst_data,
  output logic [PC_W-1:0]              inst_pc,
  input  logic                         inst_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned CW  = $clog2(DEPTH+1);
  localparam int unsigned CW1 = CW + 1;
  localparam int unsigned EW  = PC_W + INSTR_W;

  ifq_state_e       state_q, state_d;
  logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0]  mem_addr_q, mem_addr_d;
  logic [PC_W-1:0]  fetch_pc_inc;
  logic [CW1-1:0]   occ_next;
  logic             push, pop, flush, space;
  logic [EW-1:0]    head;
  logic [CW-1:0]    cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IFQ_IDLE;
      fetch_pc_q <= RESET_PC;
      mem_addr_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  // Next-state, fetch address and queue control; a redirect suppresses both push and pop.
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    mem_addr_d   = mem_addr_q;
    flush        = 1'b0;
    fetch_pc_inc = fetch_pc_q + PC_W'(1);
    pop          = inst_valid && inst_ready && !redirect;
    push         = (state_q == IFQ_WAIT) && mem_ack && !redirect;
    occ_next     = CW1'(cnt) + CW1'(push) - CW1'(pop);
    space        = occ_next < CW1'(DEPTH);
    unique case (state_q)
      IFQ_IDLE: begin
        if (redirect) begin
          fetch_pc_d = redirect_pc;
          flush      = 1'b1;
        end else if (space) begin
          mem_addr_d = fetch_pc_q;
          state_d    = IFQ_WAIT;
        end
      end
      IFQ_WAIT: begin
        if (redirect) begin
          fetch_pc_d = redirect_pc;
          flush      = 1'b1;
          state_d    = mem_ack ? IFQ_IDLE : IFQ_DROP;
        end else if (mem_ack) begin
          fetch_pc_d = fetch_pc_inc;
          if (space) mem_addr_d = fetch_pc_inc;
          else       state_d    = IFQ_IDLE;
        end
      end
      IFQ_DROP: begin
        if (redirect) begin
          fetch_pc_d = redirect_pc;
          flush      = 1'b1;
        end
        if (mem_ack) state_d = IFQ_IDLE;
      end
      default: state_d = IFQ_IDLE;
    endcase
  end

  sync_fifo_fwft #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   ({fetch_pc_q, mem_rdata}),
    .pop   (pop),
    .flush (flush),
    .dout  (head),
    .count (cnt)
  );

  assign mem_req    = (state_q != IFQ_IDLE);
  assign mem_addr   = mem_addr_q;
  assign count      = cnt;
  assign inst_valid = (cnt != '0);
  assign inst_pc    = head[EW-1:INSTR_W];
  assign inst_data  = head[INSTR_W-1:0];

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed bench for instr_prefetch_queue: streaming, backpressure, redirects, PC wrap, reset.
module tb_instr_prefetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req, mem_ack;
  logic [12:0] mem_addr;
  logic [15:0] mem_rdata;
  logic        redirect = 1'b0;
  logic [12:0] redirect_pc = '0;
  logic        inst_valid, inst_ready = 1'b0;
  logic [15:0] inst_data;
  logic [12:0] inst_pc;
  logic [2:0]  count;

  logic        mem_req_w, mem_ack_w, inst_valid_w;
  logic [12:0] mem_addr_w, inst_pc_w;
  logic [15:0] mem_rdata_w, inst_data_w;
  logic [2:0]  count_w;
  logic        redirect_w = 1'b0;
  logic        inst_ready_w = 1'b1;
  logic [12:0] redirect_pc_w = '0;

  int lat = 0;
  int wait_cnt = 0;
  int acks = 0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] data_of(input logic [12:0] a);
    return {3'b110, a} ^ 16'h0F0F;
  endfunction

  // Memory model: ack after `lat` extra cycles of held request.
  assign mem_ack     = mem_req && (wait_cnt >= lat);
  assign mem_rdata   = data_of(mem_addr);
  assign mem_ack_w   = mem_req_w;
  assign mem_rdata_w = data_of(mem_addr_w);

  always @(posedge clk) begin
    if (!mem_req || mem_ack) wait_cnt <= 0;
    else                     wait_cnt <= wait_cnt + 1;
    if (mem_req && mem_ack) acks <= acks + 1;
  end

  instr_prefetch_queue dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc),
    .inst_ready(inst_ready), .count(count)
  );

  instr_prefetch_queue #(.RESET_PC(13'h1FFE)) dut_w (
    .clk(clk), .rst(rst), .mem_req(mem_req_w), .mem_addr(mem_addr_w), .mem_ack(mem_ack_w),
    .mem_rdata(mem_rdata_w), .redirect(redirect_w), .redirect_pc(redirect_pc_w),
    .inst_valid(inst_valid_w), .inst_data(inst_data_w), .inst_pc(inst_pc_w),
    .inst_ready(inst_ready_w), .count(count_w)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    inst_ready = 1'b1;
    lat = 0;
    rst = 1'b1;
    tick();
    tick();
    total++;
    if (mem_req !== 1'b0 || mem_addr !== 13'h0) begin
      bad++; $display("FAIL reset_req: req=%b addr=%h, want req=0 addr=0", mem_req, mem_addr);
    end
    total++;
    if (inst_valid !== 1'b0 || inst_data !== 16'h0 || inst_pc !== 13'h0 || count !== 3'd0) begin
      bad++; $display("FAIL reset_q: valid=%b data=%h pc=%h cnt=%0d, want all 0",
                      inst_valid, inst_data, inst_pc, count);
    end
    rst = 1'b0;
    tick();
    total++;
    if (mem_req !== 1'b1 || mem_addr !== 13'h0 || inst_valid !== 1'b0) begin
      bad++; $display("FAIL reset_first_req: req=%b addr=%h valid=%b, want 1 0 0",
                      mem_req, mem_addr, inst_valid);
    end
  endtask

  task automatic test_zero_wait();
    inst_ready = 1'b1;
    lat = 0;
    do_reset();
    tick();
    for (int k = 1; k <= 6; k++) begin
      tick();
      total++;
      if (mem_addr !== 13'(k) || inst_valid !== 1'b1 || inst_pc !== 13'(k-1) ||
          inst_data !== data_of(13'(k-1)) || count !== 3'd1) begin
        bad++; $display("FAIL stream_%0d: addr=%h valid=%b pc=%h data=%h cnt=%0d, want %h 1 %h %h 1",
                        k, mem_addr, inst_valid, inst_pc, inst_data, count,
                        13'(k), 13'(k-1), data_of(13'(k-1)));
      end
    end
  endtask

  task automatic test_backpressure();
    int a0;
    inst_ready = 1'b0;
    lat = 0;
    do_reset();
    a0 = acks;
    for (int i = 0; i < 8; i++) tick();
    total++;
    if (count !== 3'd4 || mem_req !== 1'b0 || (acks - a0) != 4 || inst_pc !== 13'h0) begin
      bad++; $display("FAIL full: cnt=%0d req=%b acks=%0d head=%h, want 4 0 4 0",
                      count, mem_req, acks - a0, inst_pc);
    end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    total++;
    if (mem_req !== 1'b1 || mem_addr !== 13'h4 || count !== 3'd3 || inst_pc !== 13'h1) begin
      bad++; $display("FAIL pop_refetch: req=%b addr=%h cnt=%0d head=%h, want 1 4 3 1",
                      mem_req, mem_addr, count, inst_pc);
    end
    tick();
    total++;
    if (mem_req !== 1'b0 || count !== 3'd4) begin
      bad++; $display("FAIL refill: req=%b cnt=%0d, want 0 4", mem_req, count);
    end
  endtask

  task automatic test_redirect_wait();
    bit found = 1'b0;
    inst_ready = 1'b1;
    lat = 2;
    do_reset();
    for (int i = 0; i < 60; i++) begin
      tick();
      if (mem_req && mem_addr == 13'h5) begin
        found = 1'b1;
        break;
      end
    end
    total++;
    if (!found) begin
      bad++; $display("FAIL reach_addr5: no request at 5 within 60 cycles, last addr=%h", mem_addr);
    end
    tick();
    redirect = 1'b1;
    redirect_pc = 13'h0100;
    tick();
    redirect = 1'b0;
    total++;
    if (mem_req !== 1'b1 || mem_addr !== 13'h5 || count !== 3'd0 || inst_valid !== 1'b0) begin
      bad++; $display("FAIL drop_hold: req=%b addr=%h cnt=%0d valid=%b, want 1 5 0 0",
                      mem_req, mem_addr, count, inst_valid);
    end
    tick();
    total++;
    if (mem_req !== 1'b0 || count !== 3'd0 || inst_valid !== 1'b0) begin
      bad++; $display("FAIL drop_discard: req=%b cnt=%0d valid=%b, want 0 0 0",
                      mem_req, count, inst_valid);
    end
    tick();
    total++;
    if (mem_req !== 1'b1 || mem_addr !== 13'h0100) begin
      bad++; $display("FAIL redir_req: req=%b addr=%h, want 1 0100", mem_req, mem_addr);
    end
    tick();
    tick();
    tick();
    total++;
    if (inst_valid !== 1'b1 || inst_pc !== 13'h0100 || inst_data !== data_of(13'h0100)) begin
      bad++; $display("FAIL redir_first: valid=%b pc=%h data=%h, want 1 0100 %h",
                      inst_valid, inst_pc, inst_data, data_of(13'h0100));
    end
  endtask

  task automatic test_redirect_ack();
    inst_ready = 1'b0;
    lat = 0;
    do_reset();
    tick();
    tick();
    tick();
    total++;
    if (count !== 3'd2 || mem_addr !== 13'h2 || mem_ack !== 1'b1) begin
      bad++; $display("FAIL pre_redir: cnt=%0d addr=%h ack=%b, want 2 2 1", count, mem_addr, mem_ack);
    end
    redirect = 1'b1;
    redirect_pc = 13'h0040;
    inst_ready = 1'b1;
    tick();
    redirect = 1'b0;
    total++;
    if (count !== 3'd0 || inst_valid !== 1'b0 || mem_req !== 1'b0) begin
      bad++; $display("FAIL redir_ack_flush: cnt=%0d valid=%b req=%b, want 0 0 0",
                      count, inst_valid, mem_req);
    end
    tick();
    total++;
    if (mem_req !== 1'b1 || mem_addr !== 13'h0040) begin
      bad++; $display("FAIL redir_ack_req: req=%b addr=%h, want 1 0040", mem_req, mem_addr);
    end
    tick();
    total++;
    if (inst_valid !== 1'b1 || inst_pc !== 13'h0040 || inst_data !== data_of(13'h0040)) begin
      bad++; $display("FAIL redir_ack_head: valid=%b pc=%h data=%h, want 1 0040 %h",
                      inst_valid, inst_pc, inst_data, data_of(13'h0040));
    end
  endtask

  task automatic test_pc_wrap();
    logic [12:0] exp_addr [4];
    exp_addr[0] = 13'h1FFE;
    exp_addr[1] = 13'h1FFF;
    exp_addr[2] = 13'h0000;
    exp_addr[3] = 13'h0001;
    do_reset();
    tick();
    total++;
    if (mem_req_w !== 1'b1 || mem_addr_w !== 13'h1FFE || inst_valid_w !== 1'b0) begin
      bad++; $display("FAIL wrap_first: req=%b addr=%h valid=%b, want 1 1ffe 0",
                      mem_req_w, mem_addr_w, inst_valid_w);
    end
    for (int k = 1; k < 4; k++) begin
      tick();
      total++;
      if (mem_addr_w !== exp_addr[k] || inst_valid_w !== 1'b1 || inst_pc_w !== exp_addr[k-1] ||
          inst_data_w !== data_of(exp_addr[k-1])) begin
        bad++; $display("FAIL wrap_%0d: addr=%h valid=%b pc=%h data=%h, want %h 1 %h %h",
                        k, mem_addr_w, inst_valid_w, inst_pc_w, inst_data_w,
                        exp_addr[k], exp_addr[k-1], data_of(exp_addr[k-1]));
      end
    end
  endtask

  task automatic test_reset_mid();
    inst_ready = 1'b0;
    lat = 0;
    do_reset();
    for (int i = 0; i < 4; i++) tick();
    total++;
    if (count !== 3'd3 || mem_req !== 1'b1 || mem_addr !== 13'h3) begin
      bad++; $display("FAIL pre_rst: cnt=%0d req=%b addr=%h, want 3 1 3", count, mem_req, mem_addr);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (mem_req !== 1'b0 || mem_addr !== 13'h0 || inst_valid !== 1'b0 || inst_data !== 16'h0 ||
        inst_pc !== 13'h0 || count !== 3'd0) begin
      bad++; $display("FAIL mid_rst: req=%b addr=%h valid=%b data=%h pc=%h cnt=%0d, want all 0",
                      mem_req, mem_addr, inst_valid, inst_data, inst_pc, count);
    end
    tick();
    total++;
    if (mem_req !== 1'b1 || mem_addr !== 13'h0) begin
      bad++; $display("FAIL mid_rst_restart: req=%b addr=%h, want 1 0", mem_req, mem_addr);
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_backpressure();
    test_redirect_wait();
    test_redirect_ack();
    test_pc_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
